// File: rtl/echo_sched_pkg.sv
// rtl/echo_sched_pkg.sv - shared types and round-robin pick helper for the echo scheduler
package echo_sched_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int DATA_W_DEF  = 32;
  localparam int TAG_DEP_DEF = 4;
  localparam int NREQ_MAX    = 8;

  typedef logic [$clog2(NREQ_MAX)-1:0] tag_max_t;

  typedef struct packed {
    logic     found;
    tag_max_t idx;
  } rr_pick_t;

  // Walks downward so the candidate closest to ptr is the one left standing.
  function automatic rr_pick_t rr_pick(input logic [NREQ_MAX-1:0] want,
                                       input tag_max_t ptr, input int n);
    rr_pick_t r;
    int       idx;
    r = '0;
    for (int k = NREQ_MAX - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (int'(ptr) + k) % n;
        if (want[idx[2:0]]) begin
          r.found = 1'b1;
          r.idx   = tag_max_t'(idx);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/echo_rr_scheduler_if.sv
// rtl/echo_rr_scheduler_if.sv - requester, Echo and response signals of the echo scheduler
interface echo_rr_scheduler_if #(
  parameter int NREQ    = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_DEP = 4
);
  logic [NREQ-1:0]          req_want;
  logic [NREQ-1:0]          req__RDY;
  logic [NREQ-1:0]          req__ENA;
  logic [NREQ*DATA_W-1:0]   req_v;
  logic                     echoReq__RDY;
  logic                     echoReq__ENA;
  logic [DATA_W-1:0]        echoReq_v;
  logic                     rule_respond__RDY;
  logic                     rule_respond__ENA;
  logic                     ind_echo__ENA;
  logic [DATA_W-1:0]        ind_echo_v;
  logic [NREQ-1:0]          rsp__RDY;
  logic [NREQ-1:0]          rsp__ENA;
  logic [DATA_W-1:0]        rsp_v;
  logic [$clog2(TAG_DEP):0] outstanding;
  logic                     err_orphan;

  modport slave (
    input  req_want, req__ENA, req_v, echoReq__RDY, rule_respond__RDY,
           ind_echo__ENA, ind_echo_v, rsp__RDY,
    output req__RDY, echoReq__ENA, echoReq_v, rule_respond__ENA,
           rsp__ENA, rsp_v, outstanding, err_orphan
  );

  modport master (
    output req_want, req__ENA, req_v, echoReq__RDY, rule_respond__RDY,
           ind_echo__ENA, ind_echo_v, rsp__RDY,
    input  req__RDY, echoReq__ENA, echoReq_v, rule_respond__ENA,
           rsp__ENA, rsp_v, outstanding, err_orphan
  );
endinterface

// File: rtl/echo_tag_fifo.sv
// rtl/echo_tag_fifo.sv - synchronous FIFO of requester tags awaiting an Echo indication
module echo_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // The extra pointer bit separates full from empty when the indices coincide.
  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign head  = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/echo_rr_scheduler.sv
// rtl/echo_rr_scheduler.sv - round-robin sharing of one Echo datapath among NREQ requesters
module echo_rr_scheduler
  import echo_sched_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TAG_DEP = TAG_DEP_DEF
) (
  input logic                CLK,
  input logic                RST,
  echo_rr_scheduler_if.slave bus
);
  localparam int TAG_W = $clog2(NREQ);

  logic [NREQ_MAX-1:0] want_ext;
  rr_pick_t            pick;
  logic [TAG_W-1:0]    rr_ptr;
  logic [TAG_W-1:0]    winner;
  logic [TAG_W-1:0]    tag_head;
  logic                tag_full;
  logic                tag_empty;
  logic                grant_ok;
  logic                accept;
  logic                rsp_fire;
  logic                err_orphan_q;
  logic [$clog2(TAG_DEP):0] tag_count;

  always_comb begin
    want_ext            = '0;
    want_ext[NREQ-1:0]  = bus.req_want;
    pick                = rr_pick(want_ext, tag_max_t'(rr_ptr), NREQ);
  end

  assign winner = pick.idx[TAG_W-1:0];

  // Grant never looks at req__ENA, so requesters can safely decide on RDY.
  assign grant_ok = !RST && pick.found && bus.echoReq__RDY && !tag_full;
  assign accept   = grant_ok && bus.req__ENA[winner];

  always_comb begin
    bus.req__RDY = '0;
    if (grant_ok) bus.req__RDY[winner] = 1'b1;
  end

  assign bus.echoReq__ENA = accept;
  assign bus.echoReq_v    = accept ? bus.req_v[winner*DATA_W +: DATA_W] : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (winner == TAG_W'(NREQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  echo_tag_fifo #(.DEPTH(TAG_DEP), .WIDTH(TAG_W)) u_tag_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (accept),
    .pop   (rsp_fire),
    .din   (winner),
    .head  (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  // Responses leave strictly in issue order; a stalled head blocks the rest.
  assign bus.rule_respond__ENA = !RST && bus.rule_respond__RDY && !tag_empty
                                 && bus.rsp__RDY[tag_head];
  assign rsp_fire = !RST && bus.ind_echo__ENA && !tag_empty;

  always_comb begin
    bus.rsp__ENA = '0;
    if (rsp_fire) bus.rsp__ENA[tag_head] = 1'b1;
  end

  assign bus.rsp_v = rsp_fire ? bus.ind_echo_v : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_orphan_q <= 1'b0;
    end else if (bus.ind_echo__ENA && tag_empty) begin
      err_orphan_q <= 1'b1;
    end
  end

  assign bus.err_orphan  = err_orphan_q;
  assign bus.outstanding = tag_count;

  always @(posedge CLK) begin
    if (!RST) assert ((bus.req__ENA & ~bus.req__RDY) == '0);
  end
endmodule

// File: tb/tb_echo_rr_scheduler.sv
// tb/tb_echo_rr_scheduler.sv - self-checking bench for echo_rr_scheduler
module tb_echo_rr_scheduler;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TD = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  echo_rr_scheduler_if #(.NREQ(N), .DATA_W(DW), .TAG_DEP(TD)) bus ();

  echo_rr_scheduler #(.NREQ(N), .DATA_W(DW), .TAG_DEP(TD)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  int            tagq[$];
  logic [DW-1:0] payq[$];
  int            rrp;
  bit            orphan;

  logic [N-1:0]    want, acc_mask, rsprdy;
  logic [N*DW-1:0] reqv;
  logic            erdy, rrrdy;
  bit              ind_auto, ind_force;

  logic [N-1:0]  obs_rdy, obs_rsp_ena;
  logic [DW-1:0] obs_rsp_v;
  logic          obs_rr_ena;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    tagq.delete();
    payq.delete();
    rrp    = 0;
    orphan = 0;
  endtask

  // One clock of traffic: the bench plays requesters and Echo from its own model.
  task automatic step();
    int            win;
    logic [N-1:0]  exp_rdy, ena, exp_rsp;
    logic [DW-1:0] exp_ev, indv;
    bit            acc, exp_rre, fire, ind;
    win = -1;
    for (int k = 0; k < N; k++)
      if (win < 0 && want[(rrp + k) % N]) win = (rrp + k) % N;
    exp_rdy = '0;
    if (win >= 0 && erdy && tagq.size() < TD) exp_rdy[win] = 1'b1;
    ena    = exp_rdy & acc_mask;
    acc    = |ena;
    exp_ev = acc ? reqv[win*DW +: DW] : '0;
    exp_rre = rrrdy && tagq.size() > 0 && rsprdy[tagq[0]];
    ind    = ind_force || (ind_auto && exp_rre);
    indv   = (payq.size() > 0) ? payq[0] : DW'($urandom);
    fire   = ind && tagq.size() > 0;
    exp_rsp = fire ? (N'(1) << tagq[0]) : '0;

    bus.req_want          = want;
    bus.req__ENA          = ena;
    bus.req_v             = reqv;
    bus.echoReq__RDY      = erdy;
    bus.rule_respond__RDY = rrrdy;
    bus.ind_echo__ENA     = ind;
    bus.ind_echo_v        = indv;
    bus.rsp__RDY          = rsprdy;
    #3;
    obs_rdy     = bus.req__RDY;
    obs_rsp_ena = bus.rsp__ENA;
    obs_rsp_v   = bus.rsp_v;
    obs_rr_ena  = bus.rule_respond__ENA;
    chk("req_rdy", obs_rdy, exp_rdy);
    chk("echo_ena", bus.echoReq__ENA, acc);
    if (acc) chk("echo_v", bus.echoReq_v, exp_ev);
    chk("respond_ena", obs_rr_ena, exp_rre);
    chk("rsp_ena", obs_rsp_ena, exp_rsp);
    if (fire) chk("rsp_v", obs_rsp_v, indv);
    chk("outstanding", bus.outstanding, tagq.size());
    chk("err_orphan", bus.err_orphan, orphan);
    @(posedge CLK);
    if (fire) begin
      void'(tagq.pop_front());
      void'(payq.pop_front());
    end else if (ind) begin
      orphan = 1;
    end
    if (acc) begin
      tagq.push_back(win);
      payq.push_back(exp_ev);
      rrp = (win + 1) % N;
    end
    #1;
  endtask

  initial begin
    want = '1; acc_mask = '1; rsprdy = '1; erdy = 1; rrrdy = 1;
    reqv = '0; ind_auto = 1; ind_force = 0;
    bus.req_want = want; bus.req__ENA = '0; bus.req_v = '0; bus.echoReq__RDY = 1;
    bus.rule_respond__RDY = 1; bus.ind_echo__ENA = 0; bus.ind_echo_v = '0; bus.rsp__RDY = '1;
    #2;
    chk("rst_req_rdy", bus.req__RDY, 0);
    chk("rst_outstanding", bus.outstanding, 0);
    chk("rst_err_orphan", bus.err_orphan, 0);
    chk("rst_echo_ena", bus.echoReq__ENA, 0);
    @(posedge CLK); #1;
    RST = 0;
    model_reset();

    // rotation with all requesters asking and every grant taken
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rotate_grant", obs_rdy, N'(1) << (k % N));
    end

    // fill the tag FIFO with no responses
    want = '0;
    step();
    rrrdy = 0; want = '1;
    for (int k = 0; k < TD; k++) step();
    chk("fill_outstanding", bus.outstanding, TD);
    step();
    chk("fill_rdy_blocked", obs_rdy, 0);
    want = '0; rrrdy = 1;
    for (int k = 0; k < TD; k++) step();
    chk("drain_outstanding", bus.outstanding, 0);

    // issue from 2 then 0, then two responses
    reqv = '0; reqv[2*DW +: DW] = 32'h22; reqv[0 +: DW] = 32'h00;
    rrrdy = 0; want = 4'b0100; step();
    want = 4'b0001; step();
    want = '0; rrrdy = 1;
    step();
    chk("order_rsp0_ena", obs_rsp_ena, 4'b0100);
    chk("order_rsp0_v", obs_rsp_v, 32'h22);
    step();
    chk("order_rsp1_ena", obs_rsp_ena, 4'b0001);
    chk("order_rsp1_v", obs_rsp_v, 32'h00);

    // head-of-line blocking: requester 1 is head but not ready
    reqv[1*DW +: DW] = 32'h11; reqv[3*DW +: DW] = 32'h33;
    rrrdy = 0; want = 4'b0010; step();
    want = 4'b1000; step();
    want = '0; rrrdy = 1; rsprdy = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hol_respond_ena", obs_rr_ena, 0);
      chk("hol_rsp_ena", obs_rsp_ena, 0);
    end
    rsprdy = '1;
    step();
    chk("hol_rsp_first", obs_rsp_ena, 4'b0010);
    step();
    chk("hol_rsp_second", obs_rsp_ena, 4'b1000);

    // indication with nothing outstanding
    ind_auto = 0; ind_force = 1;
    step();
    chk("orphan_rsp_ena", obs_rsp_ena, 0);
    chk("orphan_set", bus.err_orphan, 1);
    ind_force = 0; ind_auto = 1;
    for (int k = 0; k < 3; k++) step();

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      want     = N'($urandom);
      acc_mask = N'($urandom);
      rsprdy   = N'($urandom);
      erdy     = ($urandom % 4) != 0;
      rrrdy    = ($urandom % 3) != 0;
      for (int i = 0; i < N; i++) reqv[i*DW +: DW] = $urandom;
      step();
    end

    // asynchronous reset in the middle of traffic
    want = '1; acc_mask = '1; erdy = 1; rrrdy = 0;
    for (int k = 0; k < 3; k++) step();
    #1 RST = 1;
    #1;
    chk("midrst_req_rdy", bus.req__RDY, 0);
    chk("midrst_echo_ena", bus.echoReq__ENA, 0);
    chk("midrst_outstanding", bus.outstanding, 0);
    chk("midrst_err_orphan", bus.err_orphan, 0);
    chk("midrst_respond_ena", bus.rule_respond__ENA, 0);
    @(posedge CLK); #1;
    RST = 0;
    model_reset();
    rrrdy = 1;
    for (int k = 0; k < 6; k++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
